// File: rtl/tile_pkg.sv
// Shared definitions for the weight server: word type, fixed-point unit,
// default sizes, FSM state encoding and the saturating update helper.
package tile_pkg;

    // One Q16.16 fixed-point weight word.
    typedef logic [31:0] word_t;

    localparam word_t FIXED_1 = 32'h0001_0000;

    localparam int NUM_NEURONS_DEF = 128;
    localparam int IMG_SZ_DEF      = 784;
    localparam int OUTPUT_SZ_DEF   = 10;
    localparam int LR_SHIFT_DEF    = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STREAM0 = 3'd1,
        S_STREAM1 = 3'd2,
        S_UPD0    = 3'd3,
        S_UPD1    = 3'd4
    } state_e;

    // w + (d >>> sh), clamped to the signed 32-bit range.
    function automatic word_t sat_add(input word_t w, input word_t d, input int sh);
        logic signed [31:0] ds;
        logic signed [32:0] s;
        ds = $signed(d) >>> sh;
        s  = {w[31], w} + {ds[31], ds};
        if (s[32] != s[31]) begin
            return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/weight_bank.sv
// Synchronous 1R1W row RAM with a registered read port. Contents are never
// reset so that weights survive a controller reset.
module weight_bank
    import tile_pkg::*;
#(
    parameter int DEPTH = IMG_SZ_DEF,
    parameter int WORDS = NUM_NEURONS_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [AW-1:0]            waddr_i,
    input  word_t [WORDS-1:0]        wdata_i,
    input  logic                     re_i,
    input  logic [AW-1:0]            raddr_i,
    output word_t [WORDS-1:0]        rdata_o
);

    word_t [WORDS-1:0] mem_q [DEPTH];
    word_t [WORDS-1:0] rdata_q;

    // Row write and registered row read; read data holds when not reading.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/weight_server.sv
// Weight server: streams layer-0/layer-1 weight rows with one-cycle read
// latency and applies per-row saturating learning updates as a two-stage
// read-modify-write (read + delta capture on the pulse, write one cycle later).
module weight_server
    import tile_pkg::*;
#(
    parameter int NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int IMG_SZ      = IMG_SZ_DEF,
    parameter int OUTPUT_SZ   = OUTPUT_SZ_DEF,
    parameter int LR_SHIFT    = LR_SHIFT_DEF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               get_weights0,
    input  logic                               get_weights1,
    input  logic                               update0,
    input  logic                               update1,
    input  logic [NUM_NEURONS-1:0][31:0]       wchange0,
    input  logic [OUTPUT_SZ-1:0][31:0]         wchange1,
    input  logic                               wr_en,
    input  logic                               wr_layer,
    input  logic [$clog2(IMG_SZ)-1:0]          wr_addr,
    input  logic [NUM_NEURONS-1:0][31:0]       wr_data,
    output logic [NUM_NEURONS-1:0][31:0]       weights0,
    output logic [OUTPUT_SZ-1:0][31:0]         weights1,
    output logic                               busy,
    output logic                               err,
    output logic [2:0]                         dbg_state_o
);

    localparam int AW0 = $clog2(IMG_SZ);
    localparam int AW1 = $clog2(NUM_NEURONS);
    localparam int CW  = (AW0 > AW1) ? AW0 : AW1;
    localparam logic [CW-1:0] LAST0 = CW'(IMG_SZ - 1);
    localparam logic [CW-1:0] LAST1 = CW'(NUM_NEURONS - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;     // stream row / next update row
    logic [CW-1:0]     wrow_q, wrow_d;   // row of the pending update write
    logic              pend_q, pend_d;   // update write due this cycle
    logic              full_q, full_d;   // every row of the layer has been read
    logic              err_q, err_d;

    word_t [NUM_NEURONS-1:0] wch0_q, rd0, upd0_data, wdata0;
    word_t [OUTPUT_SZ-1:0]   wch1_q, rd1, upd1_data, wdata1;

    logic              re0, re1, cap0, cap1, we_h0, we_h1, acc0, acc1;
    logic              we0, we1, we_u0, we_u1, req_any, idle, wr_in_range;
    logic [AW0-1:0]    raddr0, waddr0;
    logic [AW1-1:0]    raddr1, waddr1;

    assign idle    = (state_q == S_IDLE);
    assign req_any = get_weights0 | get_weights1 | update0 | update1;
    assign wr_in_range = wr_layer ? (32'(wr_addr) < 32'(NUM_NEURONS))
                                  : (32'(wr_addr) < 32'(IMG_SZ));

    // An update pulse is taken in IDLE (lowest priority) or in its own
    // update state while rows remain.
    assign acc0 = (idle && update0 && !get_weights0 && !get_weights1) ||
                  (state_q == S_UPD0 && update0 && !full_q);
    assign acc1 = (idle && update1 && !get_weights0 && !get_weights1 && !update0) ||
                  (state_q == S_UPD1 && update1 && !full_q);

    // Next-state, read-port and error decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wrow_d  = wrow_q;
        full_d  = full_q;
        pend_d  = 1'b0;
        err_d   = 1'b0;
        re0     = 1'b0;
        re1     = 1'b0;
        raddr0  = '0;
        raddr1  = '0;
        cap0    = 1'b0;
        cap1    = 1'b0;
        we_h0   = 1'b0;
        we_h1   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (get_weights0) begin
                    state_d = S_STREAM0;
                    re0     = 1'b1;
                    cnt_d   = '0;
                end else if (get_weights1) begin
                    state_d = S_STREAM1;
                    re1     = 1'b1;
                    cnt_d   = '0;
                end else if (update0) begin
                    state_d = S_UPD0;
                end else if (update1) begin
                    state_d = S_UPD1;
                end
                if (wr_en) begin
                    if (req_any || !wr_in_range) begin
                        err_d = 1'b1;
                    end else if (wr_layer) begin
                        we_h1 = 1'b1;
                    end else begin
                        we_h0 = 1'b1;
                    end
                end
            end
            S_STREAM0: begin
                if (cnt_q == LAST0) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    re0    = 1'b1;
                    raddr0 = AW0'(cnt_q + 1'b1);
                    cnt_d  = cnt_q + 1'b1;
                end
                err_d = get_weights0 | get_weights1 | update1 | wr_en;
            end
            S_STREAM1: begin
                if (cnt_q == LAST1) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    re1    = 1'b1;
                    raddr1 = AW1'(cnt_q + 1'b1);
                    cnt_d  = cnt_q + 1'b1;
                end
                err_d = get_weights0 | get_weights1 | update0 | wr_en;
            end
            S_UPD0: begin
                if (pend_q && wrow_q == LAST0) begin
                    state_d = S_IDLE;
                    full_d  = 1'b0;
                end
                err_d = get_weights0 | get_weights1 | update1 | wr_en;
            end
            S_UPD1: begin
                if (pend_q && wrow_q == LAST1) begin
                    state_d = S_IDLE;
                    full_d  = 1'b0;
                end
                err_d = get_weights0 | get_weights1 | update0 | wr_en;
            end
            default: state_d = S_IDLE;
        endcase

        if (acc0) begin
            re0    = 1'b1;
            raddr0 = AW0'(cnt_q);
            cap0   = 1'b1;
            pend_d = 1'b1;
            wrow_d = cnt_q;
            if (cnt_q == LAST0) begin
                cnt_d  = '0;
                full_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (acc1) begin
            re1    = 1'b1;
            raddr1 = AW1'(cnt_q);
            cap1   = 1'b1;
            pend_d = 1'b1;
            wrow_d = cnt_q;
            if (cnt_q == LAST1) begin
                cnt_d  = '0;
                full_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Control state; reset drops any pending update write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wrow_q  <= '0;
            pend_q  <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wrow_q  <= wrow_d;
            pend_q  <= pend_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    // Delta capture for the read-modify-write second stage.
    always_ff @(posedge clk) begin
        if (cap0) begin
            wch0_q <= wchange0;
        end
        if (cap1) begin
            wch1_q <= wchange1;
        end
    end

    // Saturating row update computed from the registered read data.
    always_comb begin
        for (int k = 0; k < NUM_NEURONS; k++) begin
            upd0_data[k] = sat_add(rd0[k], wch0_q[k], LR_SHIFT);
        end
        for (int k = 0; k < OUTPUT_SZ; k++) begin
            upd1_data[k] = sat_add(rd1[k], wch1_q[k], LR_SHIFT);
        end
    end

    assign we_u0  = pend_q && (state_q == S_UPD0);
    assign we_u1  = pend_q && (state_q == S_UPD1);
    assign we0    = we_h0 | we_u0;
    assign we1    = we_h1 | we_u1;
    assign waddr0 = we_u0 ? AW0'(wrow_q) : AW0'(wr_addr);
    assign waddr1 = we_u1 ? AW1'(wrow_q) : AW1'(wr_addr);
    assign wdata0 = we_u0 ? upd0_data : wr_data;
    assign wdata1 = we_u1 ? upd1_data : wr_data[OUTPUT_SZ-1:0];

    weight_bank #(.DEPTH(IMG_SZ), .WORDS(NUM_NEURONS)) u_bank0 (
        .clk     (clk),
        .we_i    (we0),
        .waddr_i (waddr0),
        .wdata_i (wdata0),
        .re_i    (re0),
        .raddr_i (raddr0),
        .rdata_o (rd0)
    );

    weight_bank #(.DEPTH(NUM_NEURONS), .WORDS(OUTPUT_SZ)) u_bank1 (
        .clk     (clk),
        .we_i    (we1),
        .waddr_i (waddr1),
        .wdata_i (wdata1),
        .re_i    (re1),
        .raddr_i (raddr1),
        .rdata_o (rd1)
    );

    assign weights0    = (state_q == S_STREAM0) ? rd0 : '0;
    assign weights1    = (state_q == S_STREAM1) ? rd1 : '0;
    assign busy        = (state_q != S_IDLE);
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_weight_server.sv
// Directed bench for weight_server with small sizes and hand-computed rows.
module tb_weight_server;
    import tile_pkg::*;

    localparam int NN = 4;
    localparam int IS = 6;
    localparam int OS = 2;
    localparam int LR = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                gw0, gw1, up0, up1;
    logic [NN-1:0][31:0] wch0;
    logic [OS-1:0][31:0] wch1;
    logic                wr_en, wr_layer;
    logic [2:0]          wr_addr;
    logic [NN-1:0][31:0] wr_data;
    logic [NN-1:0][31:0] weights0;
    logic [OS-1:0][31:0] weights1;
    logic                busy, err;
    logic [2:0]          dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int err_seen = 0;

    logic [127:0] exp0 [IS];
    logic [127:0] exp1 [NN];
    logic [127:0] wch_tab [IS];

    weight_server #(.NUM_NEURONS(NN), .IMG_SZ(IS), .OUTPUT_SZ(OS), .LR_SHIFT(LR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .get_weights0 (gw0),
        .get_weights1 (gw1),
        .update0      (up0),
        .update1      (up1),
        .wchange0     (wch0),
        .wchange1     (wch1),
        .wr_en        (wr_en),
        .wr_layer     (wr_layer),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .weights0     (weights0),
        .weights1     (weights1),
        .busy         (busy),
        .err          (err),
        .dbg_state_o  (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] fill(input logic [31:0] v);
        return {4{v}};
    endfunction

    task automatic host_write(input logic layer, input logic [2:0] addr, input logic [127:0] data);
        wr_en    = 1'b1;
        wr_layer = layer;
        wr_addr  = addr;
        wr_data  = data;
        next_cycle();
        wr_en    = 1'b0;
    endtask

    // Request a layer-0 stream and check each row; optionally pulse
    // get_weights1 on row inject_at.
    task automatic run_stream0(input string tag, input int inject_at);
        gw0 = 1'b1;
        next_cycle();
        gw0 = 1'b0;
        for (int r = 0; r < IS; r++) begin
            if (r == inject_at) gw1 = 1'b1;
            @(negedge clk);
            check_eq($sformatf("%s_row%0d", tag, r), 128'(weights0), exp0[r]);
            check_eq($sformatf("%s_w1zero%0d", tag, r), 128'(weights1), 128'd0);
            if (err) err_seen++;
            next_cycle();
            gw1 = 1'b0;
        end
        @(negedge clk);
        check_eq({tag, "_w0_after"}, 128'(weights0), 128'd0);
        check_eq({tag, "_busy_after"}, 128'(busy), 128'd0);
        if (err) err_seen++;
    endtask

    task automatic run_stream1(input string tag);
        gw1 = 1'b1;
        next_cycle();
        gw1 = 1'b0;
        for (int r = 0; r < NN; r++) begin
            @(negedge clk);
            check_eq($sformatf("%s_row%0d", tag, r), 128'(weights1), exp1[r]);
            check_eq($sformatf("%s_w0zero%0d", tag, r), 128'(weights0), 128'd0);
            next_cycle();
        end
        @(negedge clk);
        check_eq({tag, "_w1_after"}, 128'(weights1), 128'd0);
        check_eq({tag, "_busy_after"}, 128'(busy), 128'd0);
    endtask

    // n back-to-back update0 pulses using wch_tab; returns in the cycle
    // after the last pulse.
    task automatic upd0_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            up0  = 1'b1;
            wch0 = wch_tab[i];
            next_cycle();
        end
        up0  = 1'b0;
        wch0 = '0;
    endtask

    task automatic finish_update(input string tag);
        @(negedge clk);
        check_eq({tag, "_busy_wr"}, 128'(busy), 128'd1);
        next_cycle();
        @(negedge clk);
        check_eq({tag, "_state_idle"}, 128'(dbg_state), 128'(S_IDLE));
        next_cycle();
    endtask

    initial begin
        rst_n = 1'b0; gw0 = 1'b0; gw1 = 1'b0; up0 = 1'b0; up1 = 1'b0;
        wch0 = '0; wch1 = '0; wr_en = 1'b0; wr_layer = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 128'(busy), 128'd0);
        check_eq("rst_err", 128'(err), 128'd0);
        check_eq("rst_w0", 128'(weights0), 128'd0);
        check_eq("rst_w1", 128'(weights1), 128'd0);
        check_eq("rst_state", 128'(dbg_state), 128'(S_IDLE));
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // stream 0: word k of row r = 16r+k
        for (int r = 0; r < IS; r++) begin
            for (int k = 0; k < NN; k++) exp0[r][k*32 +: 32] = 32'(16*r + k);
            host_write(1'b0, 3'(r), exp0[r]);
        end
        run_stream0("s0", -1);
        next_cycle();

        // stream 1: row r = 100+r in both words
        for (int r = 0; r < NN; r++) begin
            exp1[r] = {64'd0, {2{32'(100 + r)}}};
            host_write(1'b1, 3'(r), exp1[r]);
        end
        run_stream1("s1");
        next_cycle();

        // out-of-range writes
        host_write(1'b1, 3'd4, fill(32'hDEAD_BEEF));
        @(negedge clk);
        check_eq("oor1_err", 128'(err), 128'd1);
        next_cycle();
        @(negedge clk);
        check_eq("oor1_err_clr", 128'(err), 128'd0);
        host_write(1'b0, 3'd6, fill(32'hDEAD_BEEF));
        @(negedge clk);
        check_eq("oor0_err", 128'(err), 128'd1);
        next_cycle();

        // update: 0x40 + (0x20 >>> 2) = 0x48
        for (int r = 0; r < IS; r++) host_write(1'b0, 3'(r), fill(32'h40));
        for (int i = 0; i < IS; i++) wch_tab[i] = fill(32'h20);
        upd0_pulses(6);
        finish_update("upd");
        for (int r = 0; r < IS; r++) exp0[r] = fill(32'h48);
        run_stream0("upd", -1);
        next_cycle();

        // saturation and sign on row 0; other rows get zero deltas
        host_write(1'b0, 3'd0, {32'h10, 32'h8000_0005, 32'h0, 32'h7FFF_FFF0});
        wch_tab[0] = {32'h10, 32'h8000_0000, 32'hFFFF_FFF8, 32'h7FFF_FFFF};
        for (int i = 1; i < IS; i++) wch_tab[i] = '0;
        upd0_pulses(6);
        finish_update("sat");
        exp0[0] = {32'h14, 32'h8000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
        run_stream0("sat", -1);
        next_cycle();

        // conflict: get_weights1 during a layer-0 stream
        err_seen = 0;
        run_stream0("cfl", 2);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            check_eq($sformatf("cfl_no_s1_%0d", i), 128'(weights1), 128'd0);
            check_eq($sformatf("cfl_idle_%0d", i), 128'(busy), 128'd0);
            if (err) err_seen++;
        end
        check_eq("cfl_err_pulses", 128'(err_seen), 128'd1);
        next_cycle();

        // reset after 3 of 6 update pulses
        for (int r = 0; r < IS; r++) host_write(1'b0, 3'(r), fill(32'h40));
        for (int i = 0; i < IS; i++) wch_tab[i] = fill(32'h20);
        upd0_pulses(3);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mrst_busy", 128'(busy), 128'd0);
        check_eq("mrst_state", 128'(dbg_state), 128'(S_IDLE));
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        for (int r = 0; r < IS; r++) exp0[r] = (r < 2) ? fill(32'h48) : fill(32'h40);
        run_stream0("mrst", -1);
        next_cycle();

        // following update targets row 0
        wch_tab[0] = fill(32'h4);
        for (int i = 1; i < IS; i++) wch_tab[i] = '0;
        upd0_pulses(6);
        finish_update("mrst2");
        exp0[0] = fill(32'h49);
        run_stream0("mrst2", -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/weight_server.md
WEIGHT_SERVER -- requirements
Module: weight_server

Interface
REQ-001 Parameter NUM_NEURONS, default 128: hidden-layer width, equal to the number of words in a layer-0 row.
REQ-002 Parameter IMG_SZ, default 784: number of layer-0 rows, one per image pixel.
REQ-003 Parameter OUTPUT_SZ, default 10: number of words in a layer-1 row; layer 1 has NUM_NEURONS rows.
REQ-004 Parameter LR_SHIFT, default 4: learning-rate arithmetic right-shift applied to each wchange word.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 get_weights0  in  1  request for a layer-0 row stream.
REQ-008 get_weights1  in  1  request for a layer-1 row stream.
REQ-009 update0  in  1  wchange0 is valid for the current layer-0 update row.
REQ-010 update1  in  1  wchange1 is valid for the current layer-1 update row.
REQ-011 wchange0  in  NUM_NEURONS x 32  signed fixed-point layer-0 row delta.
REQ-012 wchange1  in  OUTPUT_SZ x 32  signed fixed-point layer-1 row delta.
REQ-013 wr_en, wr_layer, wr_addr, wr_data  in  1, 1, clog2(IMG_SZ), NUM_NEURONS x 32  host row write; layer 1 uses the low OUTPUT_SZ words of wr_data.
REQ-014 weights0  out  NUM_NEURONS x 32  streamed layer-0 row.
REQ-015 weights1  out  OUTPUT_SZ x 32  streamed layer-1 row.
REQ-016 busy  out  1  high in any state other than S_IDLE.
REQ-017 err  out  1  one-cycle pulse when a request or write is rejected.

Function
REQ-018 The FSM SHALL have the states S_IDLE, S_STREAM0, S_STREAM1, S_UPD0, and S_UPD1.
REQ-019 In S_IDLE, get_weights0 SHALL go to S_STREAM0; otherwise get_weights1 SHALL go to S_STREAM1; otherwise update0 SHALL go to S_UPD0; otherwise update1 SHALL go to S_UPD1; priority is in that order.
REQ-020 Streams SHALL have read latency 1: if a request is sampled at cycle N, row r SHALL be driven on cycle N+1+r.
REQ-021 A layer-0 stream SHALL cover rows 0..IMG_SZ-1, and a layer-1 stream SHALL cover rows 0..NUM_NEURONS-1.
REQ-022 At the end of a stream, the FSM SHALL return to S_IDLE, and the weights bus SHALL return to 0 in the cycle after the last row.
REQ-023 weights0 and weights1 SHALL be 0 whenever their own layer is not streaming.
REQ-024 In the update states, each update pulse SHALL apply to the next row, counted from 0, as follows:
  - w[row][k] <= sat32(w[row][k] + (wchange[k] >>> LR_SHIFT));
  - the shift is arithmetic;
  - sat32 saturates to signed 32-bit.
REQ-025 Updates SHALL be a 2-stage read-modify-write: the read and the wchange capture happen in the pulse cycle, and the write happens in the next cycle.
REQ-026 Back-to-back update pulses SHALL be sustained at 1 row per cycle.
REQ-027 Cycles without an update pulse in an update state SHALL stall the row counter and perform no write.
REQ-028 After the final row's write (IMG_SZ-1 for layer 0, NUM_NEURONS-1 for layer 1), the update row counter SHALL wrap to 0 and the FSM SHALL return to S_IDLE.
REQ-029 A get_weights pulse, or an update pulse of the other layer, outside S_IDLE SHALL be ignored and SHALL pulse err.
REQ-030 A get_weights or update pulse of the same layer arriving in S_IDLE together with a higher-priority request SHALL be dropped silently.
REQ-031 wr_en SHALL be accepted only in S_IDLE with no simultaneous request, and the write SHALL be visible to a stream requested in the next cycle.
REQ-032 wr_en asserted in any other case SHALL be ignored and SHALL pulse err.
REQ-033 If wr_addr is at or beyond the row count of its layer, the write SHALL be ignored and SHALL pulse err.

Reset
REQ-034 Assertion of rst_n SHALL immediately force:
  - the FSM to S_IDLE;
  - all counters to 0;
  - weights0, weights1, busy, and err to 0;
  - any in-flight update write to be aborted.
REQ-035 Weight RAM contents SHALL NOT be reset.
REQ-036 Reset applied mid-stream or mid-update SHALL leave previously written rows intact.

Structure
REQ-037 tile_pkg SHALL hold the shared definitions used with tile: FIXED_1, a 32-bit word typedef, default parameter values, and the state enum.
REQ-038 Each layer's storage SHALL be one instance of a sub-module weight_bank: a synchronous 1R1W RAM with registered read, parameterised by depth and row width.

Verification
REQ-039 The bench SHALL use NUM_NEURONS=4, IMG_SZ=6, OUTPUT_SZ=2, and LR_SHIFT=2.
REQ-040 Stream 0: write layer-0 row r with word k = 16*r+k, then pulse get_weights0 at cycle 10 -> row r appears at cycle 11+r for r=0..5, weights0 is 0 at cycle 17, and busy is low at cycle 17.
REQ-041 Stream 1: write layer-1 rows with value 100+r, then pulse get_weights1 -> 4 rows appear back-to-back with 1-cycle latency, and weights0 stays 0 throughout.
REQ-042 Update: preload row words with 0x40 and send 6 back-to-back update0 pulses with wchange=0x20 -> every word becomes 0x48, and the FSM is in S_IDLE 2 cycles after the last pulse.
REQ-043 Saturation and sign: a word of 0x7FFFFFF0 updated with wchange 0x7FFFFFFF becomes 0x7FFFFFFF; a word of 0 updated with wchange 0xFFFFFFF8 becomes 0xFFFFFFFE.
REQ-044 Conflict: get_weights1 during S_STREAM0 -> err pulses once, the stream completes unchanged, and no layer-1 stream follows.
REQ-045 Reset mid-update: drop rst_n after 3 of 6 update pulses -> rows 0-1 are updated, rows 2-5 are unchanged, and a following update pulse targets row 0.
